// File: rtl/msg_pkg.sv
// ----------------------------------------------------------------------------
// msg_pkg
// Shared definitions for the bounding-box message path between the image
// processing stage's message writer and the READ_MSG register.
//   - Word width and FIFO depth used by msg_word_fifo and its interface.
//   - Message ID words (three ASCII letters, right-aligned in a 32-bit word).
//   - Number of words that make up one box message.
// ----------------------------------------------------------------------------
package msg_pkg;

   localparam int MSG_DATA_W        = 32;
   localparam int MSG_FIFO_DEPTH    = 256;
   localparam int MSG_FIFO_ADDR_W   = $clog2(MSG_FIFO_DEPTH);
   localparam int MSG_WORDS_PER_BOX = 3;

   // ID words: "RBB" = 0x52 0x42 0x42, and so on for the other colours.
   localparam logic [MSG_DATA_W-1:0] MSG_ID_RBB = 32'h0052_4242;
   localparam logic [MSG_DATA_W-1:0] MSG_ID_YBB = 32'h0059_4242;
   localparam logic [MSG_DATA_W-1:0] MSG_ID_GBB = 32'h0047_4242;
   localparam logic [MSG_DATA_W-1:0] MSG_ID_BBB = 32'h0042_4242;
   localparam logic [MSG_DATA_W-1:0] MSG_ID_PBB = 32'h0050_4242;

   // Position of a word inside one box message.
   typedef enum logic [1:0] {
      MSG_WORD_ID           = 2'd0,
      MSG_WORD_TOP_LEFT     = 2'd1,
      MSG_WORD_BOTTOM_RIGHT = 2'd2
   } msg_word_e;

   // True when the word is one of the known box ID words.
   function automatic logic msg_is_id(input logic [MSG_DATA_W-1:0] word);
      return (word == MSG_ID_RBB) || (word == MSG_ID_YBB) ||
             (word == MSG_ID_GBB) || (word == MSG_ID_BBB) ||
             (word == MSG_ID_PBB);
   endfunction

endpackage

// File: rtl/msg_word_fifo_if.sv
// ----------------------------------------------------------------------------
// msg_word_fifo_if
// Bundles the write/read strobes, data and status of msg_word_fifo.
//   master : the user side (drives sclr, data, wrreq, rdreq; sees status)
//   slave  : the FIFO itself
// Handshake: wrreq enqueues data on the rising clk edge unless the FIFO is
// full with no pop in the same cycle (then the word is dropped and overflow
// sets). rdreq pops the word currently on q on the rising edge when empty=0
// (otherwise it is ignored and underflow sets). There is no ready signal;
// the user watches full/empty and the sticky flags.
// ----------------------------------------------------------------------------
interface msg_word_fifo_if import msg_pkg::*; #(
   parameter int DATA_W = MSG_DATA_W,
   parameter int ADDR_W = MSG_FIFO_ADDR_W
) ();

   logic              sclr;
   logic [DATA_W-1:0] data;
   logic              wrreq;
   logic              rdreq;
   logic [DATA_W-1:0] q;
   logic [ADDR_W-1:0] usedw;
   logic              empty;
   logic              full;
   logic              overflow;
   logic              underflow;

   modport master (
      output sclr, data, wrreq, rdreq,
      input  q, usedw, empty, full, overflow, underflow
   );

   modport slave (
      input  sclr, data, wrreq, rdreq,
      output q, usedw, empty, full, overflow, underflow
   );

endinterface

// File: rtl/msg_fifo_ram.sv
// ----------------------------------------------------------------------------
// msg_fifo_ram
// Simple dual-port RAM, DATA_W x DEPTH: one write port and one read port
// whose output is registered, so synthesis maps it onto block RAM.
// A read of the address being written in the same cycle returns the old
// contents; the FIFO handles that case with its own forwarding register.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (sampled every cycle)
//   rdata  out  registered read data
// ----------------------------------------------------------------------------
module msg_fifo_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/msg_word_fifo.sv
// ----------------------------------------------------------------------------
// msg_word_fifo
// Show-ahead word FIFO for bounding-box messages. The head word sits in a
// register (q) so it is valid whenever empty=0, with no read latency.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   fifo_if  slave modport: sclr, data, wrreq, rdreq in;
//            q, usedw, empty, full, overflow, underflow out (all registered)
//
// Head management: the RAM holds every stored word, including a copy of the
// head. The RAM read port is pointed at the slot after the head every cycle,
// so "next_word" (RAM output, or the forwarding register when that slot was
// written on the same edge) always holds the second word. A pop copies it
// into q, which sustains one word per cycle. Writes that become the head
// directly (into an empty FIFO, or write+pop with one word stored) bypass
// the RAM into q.
// ----------------------------------------------------------------------------
module msg_word_fifo import msg_pkg::*; #(
   parameter int DATA_W = MSG_DATA_W,
   parameter int DEPTH  = MSG_FIFO_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           reset_n,
   msg_word_fifo_if.slave fifo_if
);

   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   // Registered state
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [DATA_W-1:0] q_r;
   logic              empty_r;
   logic              full_r;
   logic              overflow_r;
   logic              underflow_r;
   logic              fwd_valid;
   logic [DATA_W-1:0] fwd_data;

   // Next-state / control
   logic              wr_acc;
   logic              rd_acc;
   logic              ram_we;
   logic [ADDR_W-1:0] wr_ptr_nx;
   logic [ADDR_W-1:0] rd_ptr_nx;
   logic [ADDR_W:0]   count_nx;
   logic [ADDR_W-1:0] ram_raddr;
   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] next_word;

   always_comb begin
      wr_acc    = 1'b0;
      rd_acc    = 1'b0;
      ram_we    = 1'b0;
      wr_ptr_nx = wr_ptr;
      rd_ptr_nx = rd_ptr;
      count_nx  = count;

      // A pop frees a slot in the same cycle, so a full FIFO still takes a
      // write when rdreq is also asserted.
      wr_acc = fifo_if.wrreq & (~full_r | fifo_if.rdreq);
      rd_acc = fifo_if.rdreq & ~empty_r;

      if (fifo_if.sclr) begin
         wr_ptr_nx = '0;
         rd_ptr_nx = '0;
         count_nx  = '0;
      end else begin
         ram_we = wr_acc;
         if (wr_acc) wr_ptr_nx = wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr_nx = rd_ptr + PTR_ONE;
         case ({wr_acc, rd_acc})
            2'b10:   count_nx = count + CNT_ONE;
            2'b01:   count_nx = count - CNT_ONE;
            default: count_nx = count;
         endcase
      end

      // Keep the RAM read port on the slot after the head as it will be
      // after this edge.
      ram_raddr = rd_ptr_nx + PTR_ONE;

      next_word = fwd_valid ? fwd_data : ram_rdata;
   end

   msg_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (fifo_if.data),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         q_r         <= '0;
         empty_r     <= 1'b1;
         full_r      <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
         fwd_valid   <= 1'b0;
         fwd_data    <= '0;
      end else begin
         wr_ptr  <= wr_ptr_nx;
         rd_ptr  <= rd_ptr_nx;
         count   <= count_nx;
         empty_r <= (count_nx == '0);
         full_r  <= (count_nx == CNT_FULL);

         // The RAM returns old data on a same-address read/write, so capture
         // the written word when it lands on the slot being read.
         fwd_valid <= ram_we && (wr_ptr == ram_raddr);
         fwd_data  <= fifo_if.data;

         if (fifo_if.sclr) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
         end else begin
            if (fifo_if.wrreq && !wr_acc) overflow_r  <= 1'b1;
            if (fifo_if.rdreq && empty_r) underflow_r <= 1'b1;

            // Head register update; q is left alone when the last word is
            // popped so it keeps the value just read.
            if (wr_acc && empty_r) begin
               q_r <= fifo_if.data;
            end else if (rd_acc && (count == CNT_ONE) && wr_acc) begin
               q_r <= fifo_if.data;
            end else if (rd_acc && (count > CNT_ONE)) begin
               q_r <= next_word;
            end
         end
      end
   end

   assign fifo_if.q         = q_r;
   assign fifo_if.usedw     = count[ADDR_W-1:0];
   assign fifo_if.empty     = empty_r;
   assign fifo_if.full      = full_r;
   assign fifo_if.overflow  = overflow_r;
   assign fifo_if.underflow = underflow_r;

endmodule

// File: tb/tb_msg_word_fifo.sv
// ----------------------------------------------------------------------------
// tb_msg_word_fifo
// Self-checking bench for msg_word_fifo: directed scenarios followed by a
// random mixed read/write run, all compared against a reference queue.
// ----------------------------------------------------------------------------
module tb_msg_word_fifo;
   import msg_pkg::*;

   localparam int DEPTH = MSG_FIFO_DEPTH;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   msg_word_fifo_if fifo_if ();

   msg_word_fifo dut (
      .clk     (clk),
      .reset_n (reset_n),
      .fifo_if (fifo_if)
   );

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   logic        m_ovf;
   logic        m_unf;
   int          n_checks;
   int          n_pass;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // Compare every status output (and q when words are stored) to the model.
   task automatic check_status(input string tag);
      logic [8:0] sz;
      sz = 9'(exp_q.size());
      check_val({tag, ".usedw"}, 32'(fifo_if.usedw), 32'(sz[7:0]));
      check_val({tag, ".empty"}, 32'(fifo_if.empty), 32'(sz == 9'd0));
      check_val({tag, ".full"},  32'(fifo_if.full),  32'(sz == 9'(DEPTH)));
      check_val({tag, ".ovf"},   32'(fifo_if.overflow),  32'(m_ovf));
      check_val({tag, ".unf"},   32'(fifo_if.underflow), 32'(m_unf));
      if (sz != 9'd0) check_val({tag, ".q"}, fifo_if.q, exp_q[0]);
   endtask

   // ---------------- driver ----------------
   // One clock cycle of stimulus; the model advances on the same edge and
   // the DUT is sampled 1 time unit after it.
   task automatic step(input string tag, input bit wr, input logic [31:0] wd,
                       input bit rd, input bit clr);
      bit m_empty, m_full, rd_ok, wr_ok;
      logic [31:0] popped;
      fifo_if.wrreq = wr;
      fifo_if.data  = wd;
      fifo_if.rdreq = rd;
      fifo_if.sclr  = clr;
      m_empty = (exp_q.size() == 0);
      m_full  = (exp_q.size() == DEPTH);
      rd_ok   = rd && !m_empty;
      wr_ok   = wr && (!m_full || rd);
      // A pop returns the word on q before the edge.
      if (!clr && rd_ok) check_val({tag, ".pop"}, fifo_if.q, exp_q[0]);
      @(posedge clk);
      if (clr) begin
         model_clear();
      end else begin
         if (rd && m_empty) m_unf = 1'b1;
         if (wr && !wr_ok)  m_ovf = 1'b1;
         if (rd_ok) popped = exp_q.pop_front();
         if (wr_ok) exp_q.push_back(wd);
      end
      #1;
      check_status(tag);
   endtask

   task automatic idle_inputs();
      fifo_if.wrreq = 1'b0;
      fifo_if.rdreq = 1'b0;
      fifo_if.sclr  = 1'b0;
      fifo_if.data  = '0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_pass   = 0;
      model_clear();
      idle_inputs();

      // Reset, then idle
      repeat (2) @(posedge clk);
      #1;
      check_val("rst.q", fifo_if.q, 32'h0);
      check_status("rst");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("idle.q", fifo_if.q, 32'h0);
      check_status("idle");

      // Read while empty sets underflow
      step("unf", 1'b0, 32'h0, 1'b1, 1'b0);

      // Three-word message, then drain it back to back
      step("msg_w0", 1'b1, MSG_ID_RBB,   1'b0, 1'b0);
      step("msg_w1", 1'b1, 32'h01230045, 1'b0, 1'b0);
      step("msg_w2", 1'b1, 32'h02340067, 1'b0, 1'b0);
      for (int i = 0; i < MSG_WORDS_PER_BOX; i++) step("msg_rd", 1'b0, 32'h0, 1'b1, 1'b0);

      // Fill to full, overflow write, drain in order
      step("clr0", 1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 32'(i), 1'b0, 1'b0);
      step("ovf", 1'b1, 32'hDEAD, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 32'h0, 1'b1, 1'b0);

      // Simultaneous write/read with one word stored and with full
      step("clr1", 1'b0, 32'h0, 1'b0, 1'b1);
      step("one_w", 1'b1, 32'hA, 1'b0, 1'b0);
      step("one_wr", 1'b1, 32'hB, 1'b1, 1'b0);
      check_val("one_wr.qB", fifo_if.q, 32'hB);
      step("one_rd", 1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
      step("full_wr", 1'b1, 32'hC, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 32'h0, 1'b1, 1'b0);

      // sclr with a concurrent write wins; flags cleared
      step("unf2", 1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step("fill10", 1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0);
      step("sclr", 1'b1, 32'h77, 1'b0, 1'b1);
      step("post_sclr", 1'b1, 32'h55, 1'b0, 1'b0);
      check_val("post_sclr.q55", fifo_if.q, 32'h55);

      // Asynchronous reset mid-burst
      for (int i = 0; i < 100; i++) step("burst", 1'b1, $urandom, 1'b0, 1'b0);
      idle_inputs();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      model_clear();
      #1;
      check_val("arst.q", fifo_if.q, 32'h0);
      check_status("arst");
      @(negedge clk);
      reset_n = 1'b1;

      // Random mixed traffic, alternating fill-heavy and drain-heavy phases
      for (int p = 0; p < 10; p++) begin
         int wr_pct, rd_pct;
         wr_pct = (p % 2 == 0) ? 80 : 30;
         rd_pct = (p % 2 == 0) ? 30 : 80;
         for (int c = 0; c < 1000; c++) begin
            bit wr, rd, clr;
            wr  = ($urandom_range(0, 99) < wr_pct);
            rd  = ($urandom_range(0, 99) < rd_pct);
            clr = ($urandom_range(0, 999) == 0);
            step("rand", wr, $urandom, rd, clr);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
